// File: rtl/bullet_scheduler.sv
// Bullet slot pool controller: fire arbitration, slot allocation/release, periodic move sweep.
// Define BULLET_SCHED_STATS_EN to add saturating per-player grant counters shots0/shots1.
module bullet_scheduler #(
  parameter int MAX_BULLETS    = 8,
  parameter int MAX_PER_PLAYER = 4,
  parameter int COOLDOWN       = 800000,
  parameter int MOVE_TIME      = 80000,
  parameter int SW             = $clog2(MAX_BULLETS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   game_over,
  input  logic [1:0]             fire_req,
  input  logic [1:0]             fire_dir0,
  input  logic [1:0]             fire_dir1,
  input  logic [9:0]             tank0_x,
  input  logic [9:0]             tank0_y,
  input  logic [9:0]             tank1_x,
  input  logic [9:0]             tank1_y,
  input  logic                   release_valid,
  input  logic [SW-1:0]          release_slot,
  output logic                   alloc_valid,
  output logic [SW-1:0]          alloc_slot,
  output logic                   alloc_owner,
  output logic [9:0]             alloc_x,
  output logic [9:0]             alloc_y,
  output logic [1:0]             alloc_dir,
  output logic                   step_valid,
  output logic [SW-1:0]          step_slot,
  output logic [MAX_BULLETS-1:0] slot_busy,
  output logic [MAX_BULLETS-1:0] slot_owner,
  output logic                   flush
`ifdef BULLET_SCHED_STATS_EN
  ,
  output logic [15:0]            shots0,
  output logic [15:0]            shots1
`endif
);

  localparam int CW = $clog2(MAX_PER_PLAYER + 1);
  localparam int DW = $clog2(COOLDOWN + 1);
  localparam int MW = $clog2(MOVE_TIME + 1);

  typedef enum logic {ST_WAIT, ST_SWEEP} state_e;

  state_e                   state_q, state_d;
  logic [SW-1:0]            idx_q, idx_d;
  logic [MW-1:0]            mcnt_q, mcnt_d;
  logic [MAX_BULLETS-1:0]   busy_q, busy_d, owner_q, owner_d;
  logic [1:0][CW-1:0]       cnt_q, cnt_d;
  logic [1:0][DW-1:0]       cool_q, cool_d;
  logic                     rr_q, rr_d;
  logic                     go_q;
  logic                     flush_q, flush_d;
  logic                     alloc_valid_q, alloc_valid_d;
  logic [SW-1:0]            alloc_slot_q, alloc_slot_d;
  logic                     alloc_owner_q, alloc_owner_d;
  logic [9:0]               alloc_x_q, alloc_x_d, alloc_y_q, alloc_y_d;
  logic [1:0]               alloc_dir_q, alloc_dir_d;

  logic                     free_found;
  logic [SW-1:0]            free_idx;
  logic [1:0]               elig;
  logic                     grant, win, go_rise;
  logic                     rel_hit, rel_own;
  logic [9:0]               tx, ty, sx, sy;
  logic [1:0]               tdir;
  logic                     step_c;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < MAX_BULLETS; i++) begin
      if (!free_found && !busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
    end

    go_rise = game_over & ~go_q;
    for (int unsigned p = 0; p < 2; p++) begin
      elig[p] = fire_req[p] && (cool_q[p] == '0) && (cnt_q[p] < CW'(MAX_PER_PLAYER))
                && free_found && !game_over;
    end
    grant = |elig;
    win   = (&elig) ? rr_q : elig[1];
    rr_d  = (&elig) ? ~rr_q : rr_q;

    rel_hit = release_valid && busy_q[release_slot];
    rel_own = owner_q[release_slot];

    // Release targets a busy slot and allocation picks a free one, so both may apply together.
    busy_d  = busy_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (rel_hit) begin
      busy_d[release_slot] = 1'b0;
      cnt_d[rel_own]       = cnt_d[rel_own] - CW'(1);
    end
    if (grant) begin
      busy_d[free_idx]  = 1'b1;
      owner_d[free_idx] = win;
      cnt_d[win]        = cnt_d[win] + CW'(1);
    end
    if (go_rise) begin
      busy_d  = '0;
      owner_d = '0;
      cnt_d   = '0;
    end

    for (int unsigned p = 0; p < 2; p++) begin
      cool_d[p] = cool_q[p];
      if (!game_over) begin
        if (grant && (win == 1'(p))) cool_d[p] = DW'(COOLDOWN - 1);
        else if (cool_q[p] != '0)    cool_d[p] = cool_q[p] - DW'(1);
      end
    end

    tx   = win ? tank1_x : tank0_x;
    ty   = win ? tank1_y : tank0_y;
    tdir = win ? fire_dir1 : fire_dir0;
    case (tdir)
      2'b00:   begin sx = tx + 10'd12; sy = ty - 10'd8;  end
      2'b01:   begin sx = tx + 10'd12; sy = ty + 10'd32; end
      2'b10:   begin sx = tx - 10'd8;  sy = ty + 10'd12; end
      default: begin sx = tx + 10'd32; sy = ty + 10'd12; end
    endcase

    alloc_valid_d = grant;
    alloc_slot_d  = grant ? free_idx : alloc_slot_q;
    alloc_owner_d = grant ? win      : alloc_owner_q;
    alloc_x_d     = grant ? sx       : alloc_x_q;
    alloc_y_d     = grant ? sy       : alloc_y_q;
    alloc_dir_d   = grant ? tdir     : alloc_dir_q;
    flush_d       = go_rise;
  end

  // Move counter free-runs so sweeps start every MOVE_TIME cycles regardless of sweep length.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mcnt_d  = mcnt_q;
    step_c  = 1'b0;
    if (game_over) begin
      state_d = ST_WAIT;
      idx_d   = '0;
    end else begin
      mcnt_d = (mcnt_q == '0) ? MW'(MOVE_TIME - 1) : mcnt_q - MW'(1);
      case (state_q)
        ST_WAIT: begin
          if (mcnt_q == '0) begin
            state_d = ST_SWEEP;
            idx_d   = '0;
          end
        end
        ST_SWEEP: begin
          step_c = busy_q[idx_q] && !(release_valid && (release_slot == idx_q));
          idx_d  = idx_q + SW'(1);
          if (idx_q == SW'(MAX_BULLETS - 1)) state_d = ST_WAIT;
        end
        default: state_d = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_WAIT;
      idx_q         <= '0;
      mcnt_q        <= MW'(MOVE_TIME - 1);
      busy_q        <= '0;
      owner_q       <= '0;
      cnt_q         <= '0;
      cool_q        <= '0;
      rr_q          <= 1'b0;
      go_q          <= 1'b0;
      flush_q       <= 1'b0;
      alloc_valid_q <= 1'b0;
      alloc_slot_q  <= '0;
      alloc_owner_q <= 1'b0;
      alloc_x_q     <= '0;
      alloc_y_q     <= '0;
      alloc_dir_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      mcnt_q        <= mcnt_d;
      busy_q        <= busy_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      cool_q        <= cool_d;
      rr_q          <= rr_d;
      go_q          <= game_over;
      flush_q       <= flush_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_slot_q  <= alloc_slot_d;
      alloc_owner_q <= alloc_owner_d;
      alloc_x_q     <= alloc_x_d;
      alloc_y_q     <= alloc_y_d;
      alloc_dir_q   <= alloc_dir_d;
    end
  end

`ifdef BULLET_SCHED_STATS_EN
  logic [1:0][15:0] shots_q, shots_d;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      shots_d[p] = shots_q[p];
      if (grant && (win == 1'(p)) && (shots_q[p] != '1)) shots_d[p] = shots_q[p] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) shots_q <= '0;
    else          shots_q <= shots_d;
  end

  assign shots0 = shots_q[0];
  assign shots1 = shots_q[1];
`endif

  assign alloc_valid = alloc_valid_q;
  assign alloc_slot  = alloc_slot_q;
  assign alloc_owner = alloc_owner_q;
  assign alloc_x     = alloc_x_q;
  assign alloc_y     = alloc_y_q;
  assign alloc_dir   = alloc_dir_q;
  assign step_valid  = step_c;
  assign step_slot   = step_c ? idx_q : '0;
  assign slot_busy   = busy_q;
  assign slot_owner  = owner_q;
  assign flush       = flush_q;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Scoreboard bench for bullet_scheduler: directed scenarios push expected alloc/step events; a negedge monitor checks them.
module tb_bullet_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       game_over;
  logic [1:0] fire_req, fire_dir0, fire_dir1;
  logic [9:0] tank0_x, tank0_y, tank1_x, tank1_y;
  logic       release_valid;
  logic [1:0] release_slot;
  logic       alloc_valid, alloc_owner, step_valid, flush;
  logic [1:0] alloc_slot, alloc_dir, step_slot;
  logic [9:0] alloc_x, alloc_y;
  logic [3:0] slot_busy, slot_owner;
`ifdef BULLET_SCHED_STATS_EN
  logic [15:0] shots0, shots1;
`endif

  always #5 clk = ~clk;

  bullet_scheduler #(
    .MAX_BULLETS(4),
    .MAX_PER_PLAYER(2),
    .COOLDOWN(3),
    .MOVE_TIME(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .game_over(game_over), .fire_req(fire_req),
    .fire_dir0(fire_dir0), .fire_dir1(fire_dir1),
    .tank0_x(tank0_x), .tank0_y(tank0_y), .tank1_x(tank1_x), .tank1_y(tank1_y),
    .release_valid(release_valid), .release_slot(release_slot),
    .alloc_valid(alloc_valid), .alloc_slot(alloc_slot), .alloc_owner(alloc_owner),
    .alloc_x(alloc_x), .alloc_y(alloc_y), .alloc_dir(alloc_dir),
    .step_valid(step_valid), .step_slot(step_slot),
    .slot_busy(slot_busy), .slot_owner(slot_owner), .flush(flush)
`ifdef BULLET_SCHED_STATS_EN
    , .shots0(shots0), .shots1(shots1)
`endif
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  slot;
    logic        owner;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [1:0]  dir;
  } alloc_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  slot;
  } step_t;

  alloc_t aq[$];
  step_t  sq[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;

  logic [37:0] all_out;
  assign all_out = {alloc_valid, alloc_slot, alloc_owner, alloc_x, alloc_y, alloc_dir,
                    step_valid, step_slot, slot_busy, slot_owner, flush};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic ea(input int c, input int s, input int o, input int x, input int y, input int d);
    alloc_t e;
    e = '{32'(c), 2'(s), 1'(o), 10'(x), 10'(y), 2'(d)};
    aq.push_back(e);
  endtask

  task automatic es(input int c, input int s);
    step_t e;
    e = '{32'(c), 2'(s)};
    sq.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    game_over = 1'b0; fire_req = '0; fire_dir0 = '0; fire_dir1 = '0;
    tank0_x = '0; tank0_y = '0; tank1_x = '0; tank1_y = '0;
    release_valid = 1'b0; release_slot = '0;
    aq.delete();
    sq.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic tanks_std();
    tank0_x = 10'd100; tank0_y = 10'd50;  fire_dir0 = 2'b11;
    tank1_x = 10'd200; tank1_y = 10'd300; fire_dir1 = 2'b01;
  endtask

  always @(negedge clk) begin
    alloc_t a, e;
    step_t  sa, se;
    if (reset_n) begin
      if (alloc_valid) begin
        a = '{32'(cyc), alloc_slot, alloc_owner, alloc_x, alloc_y, alloc_dir};
        checks++;
        if (aq.size() == 0) begin
          errors++;
          $display("FAIL alloc_unexpected: got cyc=%0d slot=%0d owner=%0d xy=(%0d,%0d) dir=%0d, expected none",
                   a.cyc, a.slot, a.owner, a.x, a.y, a.dir);
        end else begin
          e = aq.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL alloc: got cyc=%0d slot=%0d owner=%0d xy=(%0d,%0d) dir=%0d, expected cyc=%0d slot=%0d owner=%0d xy=(%0d,%0d) dir=%0d",
                     a.cyc, a.slot, a.owner, a.x, a.y, a.dir, e.cyc, e.slot, e.owner, e.x, e.y, e.dir);
          end
        end
      end
      if (step_valid) begin
        sa = '{32'(cyc), step_slot};
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL step_unexpected: got cyc=%0d slot=%0d, expected none", sa.cyc, sa.slot);
        end else begin
          se = sq.pop_front();
          if (sa !== se) begin
            errors++;
            $display("FAIL step: got cyc=%0d slot=%0d, expected cyc=%0d slot=%0d",
                     sa.cyc, sa.slot, se.cyc, se.slot);
          end
        end
      end
    end
  end

  initial begin
    // Scenario A: single shooter, quota limit, release and re-allocation, wrap arithmetic
    do_reset();
    fire_req = 2'b01; fire_dir0 = 2'b11; tank0_x = 10'd100; tank0_y = 10'd50;
    ea(1, 0, 0, 132, 62, 3);
    ea(4, 1, 0, 16, 1018, 0);
    ea(10, 0, 0, 1012, 1012, 2);
    es(9, 1);
    @(negedge clk);
    chk("reset_outputs", 64'(all_out), 64'(0));
    tick();
    fire_dir0 = 2'b00; tank0_x = 10'd4; tank0_y = 10'd2;
    @(negedge clk);
    chk("A_busy_c1", 64'(slot_busy), 64'(4'b0001));
    tick(3);
    tank0_x = 10'd1020; tank0_y = 10'd1000; fire_dir0 = 2'b10;
    @(negedge clk);
    chk("A_busy_c4", 64'(slot_busy), 64'(4'b0011));
    tick(4);
    release_valid = 1'b1; release_slot = 2'd0;
    tick();
    release_valid = 1'b0;
    tick(3);
    fire_req = 2'b00;
    @(negedge clk);
    chk("A_busy_end", 64'(slot_busy), 64'(4'b0011));
    chk("A_owner_end", 64'(slot_owner), 64'(4'b0000));
    tick();
    @(negedge clk);
    chk("A_drained", 64'(aq.size() + sq.size()), 64'(0));

    // Scenario B: both players firing, round-robin, cooldown spacing, sweep over a full pool
    do_reset();
    tanks_std();
    fire_req = 2'b11;
    ea(1, 0, 0, 132, 62, 3);
    ea(2, 1, 1, 212, 332, 1);
    ea(4, 2, 0, 132, 62, 3);
    ea(5, 3, 1, 212, 332, 1);
    tick(5);
    fire_req = 2'b00; release_valid = 1'b1; release_slot = 2'd1;
    @(negedge clk);
    chk("B_busy_full", 64'(slot_busy), 64'(4'b1111));
    chk("B_owner_full", 64'(slot_owner), 64'(4'b1010));
    tick();
    release_slot = 2'd2;
    tick();
    release_valid = 1'b0; fire_req = 2'b11;
    ea(8, 1, 1, 212, 332, 1);
    ea(9, 2, 0, 132, 62, 3);
    es(8, 0); es(9, 1); es(10, 2); es(11, 3);
    @(negedge clk);
    chk("B_busy_after_rel", 64'(slot_busy), 64'(4'b1001));
    tick(3);
    fire_req = 2'b00;
    tick(2);
    @(negedge clk);
    chk("B_busy_end", 64'(slot_busy), 64'(4'b1111));
    chk("B_owner_end", 64'(slot_owner), 64'(4'b1010));
    tick();
    @(negedge clk);
    chk("B_drained", 64'(aq.size() + sq.size()), 64'(0));

    // Scenario C: slots 0 and 2 busy, two consecutive sweeps, ignored release of a free slot
    do_reset();
    tanks_std();
    fire_req = 2'b11;
    ea(1, 0, 0, 132, 62, 3);
    ea(2, 1, 1, 212, 332, 1);
    ea(4, 2, 0, 132, 62, 3);
    es(8, 0); es(10, 2); es(16, 0); es(18, 2);
    tick(2);
    fire_req = 2'b01;
    tick(2);
    fire_req = 2'b00; release_valid = 1'b1; release_slot = 2'd1;
    tick();
    release_slot = 2'd3;
    tick();
    release_valid = 1'b0; fire_req = 2'b01;
    @(negedge clk);
    chk("C_busy", 64'(slot_busy), 64'(4'b0101));
    tick();
    fire_req = 2'b00;
    tick(13);
    @(negedge clk);
    chk("C_drained", 64'(aq.size() + sq.size()), 64'(0));

    // Scenario D: game_over flush with held cooldown/move counter, then async reset mid-sweep
    do_reset();
    tanks_std();
    fire_req = 2'b11;
    ea(1, 0, 0, 132, 62, 3);
    ea(2, 1, 1, 212, 332, 1);
    ea(4, 2, 0, 132, 62, 3);
    ea(5, 3, 1, 212, 332, 1);
    tick(6);
    game_over = 1'b1;
    @(negedge clk);
    chk("D_busy_before_flush", 64'(slot_busy), 64'(4'b1111));
    chk("D_no_flush_yet", 64'(flush), 64'(0));
    tick();
    @(negedge clk);
    chk("D_flush_pulse", 64'(flush), 64'(1));
    chk("D_busy_flushed", 64'(slot_busy), 64'(4'b0000));
    chk("D_owner_flushed", 64'(slot_owner), 64'(4'b0000));
    tick();
    @(negedge clk);
    chk("D_flush_one_cycle", 64'(flush), 64'(0));
    tick(4);
    game_over = 1'b0;
    ea(13, 0, 0, 132, 62, 3);
    ea(14, 1, 1, 212, 332, 1);
    es(14, 0); es(15, 1);
    tick(2);
    fire_req = 2'b00;
    tick();
    @(negedge clk);
    chk("D_busy_pre_reset", 64'(slot_busy), 64'(4'b0011));
    chk("D_step_pre_reset", 64'(step_valid), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("D_async_reset_outputs", 64'(all_out), 64'(0));
    chk("D_drained", 64'(aq.size() + sq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bullet_scheduler.md
Name: bullet_scheduler

Overview:
- Shared controller for the bullet slot pool used by both tanks.
- Arbitrates fire requests from player 0 and player 1, enforces per-player cooldown and per-player slot quota, and allocates free slots with the correct spawn coordinates.
- Generates the periodic move sweep that tells the bullet datapath which active slot to step, one slot per cycle.
- Sits between the tank input logic and the bullet datapath; the datapath reports bullet deaths back through the release port.

Parameters:
MAX_BULLETS, 8, slot pool size, power of two, minimum 2
MAX_PER_PLAYER, 4, maximum concurrently busy slots owned by one player
COOLDOWN, 800000, cycles after a grant before the same player may be granted again
MOVE_TIME, 80000, cycles between move sweeps, minimum MAX_BULLETS+1
SW, $clog2(MAX_BULLETS), slot index width (derived)

Ports:
clk  in  1  system clock
reset_n  in  1  reset; asynchronous, active-low
game_over  in  1  level; freezes and flushes the pool
fire_req  in  2  level fire request per player (bit p = player p)
fire_dir0, fire_dir1  in  2 each  requested direction: 00 up, 01 down, 10 left, 11 right
tank0_x, tank0_y, tank1_x, tank1_y  in  10 each  tank top-left pixel
release_valid  in  1  datapath reports a bullet died
release_slot  in  SW  slot that died
alloc_valid  out  1  one-cycle pulse: load new bullet into alloc_slot
alloc_slot  out  SW  slot being allocated
alloc_owner  out  1  owning player
alloc_x, alloc_y  out  10 each  spawn coordinates
alloc_dir  out  2  spawn direction
step_valid  out  1  one-cycle pulse: advance bullet step_slot by one pixel
step_slot  out  SW  slot to step
slot_busy  out  MAX_BULLETS  occupancy vector
slot_owner  out  MAX_BULLETS  owner bit per slot
flush  out  1  one-cycle pulse on the rising edge of game_over

Behaviour:
- Reset values: all outputs 0; cooldown counters 0; quota counters 0; round-robin pointer favours player 0; move counter MOVE_TIME-1; FSM in WAIT.
- Eligibility: player p is eligible when fire_req[p]=1, its cooldown is 0, its busy-owned count is below MAX_PER_PLAYER, at least one slot is free, and game_over=0.
- Arbitration:
  - One grant per cycle at most.
  - If both players are eligible, the player selected by the round-robin pointer wins and the pointer flips to the other player.
  - A single eligible player wins and the pointer is unchanged.
  - The losing request is not queued; it wins on a later cycle only if still asserted.
- Allocation:
  - Registered outputs: alloc_* are valid the cycle after the eligibility evaluation.
  - The lowest-index free slot is chosen, using slot_busy as it stands at the start of the cycle.
  - slot_busy and slot_owner update in the same edge that asserts alloc_valid.
  - The winner's cooldown loads COOLDOWN-1 and decrements to 0.
- Spawn coordinates, 10-bit modulo-1024 arithmetic:
  - up: (x+12, y-8)
  - down: (x+12, y+32)
  - left: (x-8, y+12)
  - right: (x+32, y+12)
- Release:
  - release_valid clears slot_busy[release_slot] and decrements that owner's count.
  - Release of a non-busy slot is ignored.
  - A slot released in cycle N is allocatable from cycle N+1.
  - Release and allocation in the same cycle on different slots both take effect.
- Move FSM:
  - WAIT: move counter decrements each cycle; at 0 it reloads MOVE_TIME-1 and goes to SWEEP with index 0.
  - SWEEP: visits index 0..MAX_BULLETS-1, one per cycle. step_valid=1 with step_slot=index only if that slot is busy at that cycle. After the last index, returns to WAIT.
  - A slot allocated during a sweep is stepped only if its index has not yet been visited.
  - A slot released in the same cycle it is visited is not stepped.
- game_over:
  - While high: no grants, FSM forced to WAIT, move counter held, cooldowns held.
  - On the rising edge: flush pulses for one cycle and all slot_busy, slot_owner and quota counters clear.
  - Falling edge: normal operation resumes.
- Asynchronous reset mid-sweep or mid-cooldown returns every register to its reset value immediately.

Optional Feature:
BULLET_SCHED_STATS_EN
- Defined: adds outputs shots0, shots1 (16 bits each), counting grants per player. They saturate at 16'hFFFF, clear on reset, and hold through game_over.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
Bench parameters for all scenarios: MAX_BULLETS=4, MAX_PER_PLAYER=2, COOLDOWN=3, MOVE_TIME=8.
1. Reset, then fire_req=01, fire_dir0=11, tank0=(100,50) -> next cycle alloc_valid=1, slot 0, owner 0, (132,62), dir 11; slot_busy=0001.
2. fire_req=11 held from idle -> player 0 granted first, then player 1, alternating; each player is granted again no sooner than 3 cycles after its last grant.
3. Player 0 held firing -> after 2 grants, no further grants for player 0 until a release_valid for a player-0 slot; allocation resumes the cycle after the release.
4. Slots 0 and 2 busy, move counter expires -> step_valid pulses with step_slot=0 and then 2 across the 4 sweep cycles; next sweep starts 8 cycles after the previous one.
5. tank0=(4,2), fire_dir0=00 -> alloc_x=16, alloc_y=1018 (modulo-1024 wrap).
6. All slots busy, game_over rises -> flush pulses for 1 cycle, slot_busy=0000, no grants while game_over is high; reset_n low mid-sweep -> all outputs 0 immediately.
